// File: rtl/wb_bus_arb_if.sv
// Core-side request/response signals and the WISHBONE master bus of wb_bus_arb.
// The master modport is the arbiter's view; the slave modport is the core + bus fabric view.
interface wb_bus_arb_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        pause;
    logic        bus_err;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output i_rdata, i_done, d_rdata, d_done, pause, bus_err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  i_rdata, i_done, d_rdata, d_done, pause, bus_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );
endinterface

// File: rtl/wb_bus_arb.sv
// Two-port WISHBONE master sequencer for the mips789 core: data requests win over fetches,
// one classic single cycle at a time, with a watchdog that terminates unacknowledged cycles.
module wb_bus_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    wb_bus_arb_if.master bus
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StDCyc, StICyc, StDone} state_e;

    state_e     state_q;
    logic [7:0] wdog_q;
    logic       term;

    // Done pulses are registered, so the stall drops during the DONE cycle itself.
    assign bus.pause = (bus.d_req & ~bus.d_done) | (bus.i_req & ~bus.i_done);

    assign term = bus.wb_ack_i | bus.wb_err_i | (wdog_q == TimeoutCnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wdog_q       <= 8'd0;
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.wb_we_o  <= 1'b0;
            bus.wb_adr_o <= 32'h0;
            bus.wb_sel_o <= 4'h0;
            bus.wb_dat_o <= 32'h0;
            bus.i_rdata  <= 32'h0;
            bus.d_rdata  <= 32'h0;
            bus.i_done   <= 1'b0;
            bus.d_done   <= 1'b0;
            bus.bus_err  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.d_req) begin
                        bus.wb_adr_o <= bus.d_addr;
                        bus.wb_we_o  <= bus.d_we;
                        bus.wb_sel_o <= bus.d_be;
                        bus.wb_dat_o <= bus.d_wdata;
                        bus.wb_cyc_o <= 1'b1;
                        bus.wb_stb_o <= 1'b1;
                        wdog_q       <= 8'd0;
                        state_q      <= StDCyc;
                    end else if (bus.i_req) begin
                        bus.wb_adr_o <= bus.i_addr;
                        bus.wb_we_o  <= 1'b0;
                        bus.wb_sel_o <= 4'hF;
                        bus.wb_cyc_o <= 1'b1;
                        bus.wb_stb_o <= 1'b1;
                        wdog_q       <= 8'd0;
                        state_q      <= StICyc;
                    end
                end
                StDCyc, StICyc: begin
                    if (term) begin
                        bus.wb_cyc_o <= 1'b0;
                        bus.wb_stb_o <= 1'b0;
                        bus.wb_we_o  <= 1'b0;
                        state_q      <= StDone;
                        if (state_q == StDCyc) begin
                            bus.d_done <= 1'b1;
                        end else begin
                            bus.i_done <= 1'b1;
                        end
                        // Ack wins over err; a failed read returns zero, writes leave d_rdata alone.
                        if (!bus.wb_ack_i) begin
                            bus.bus_err <= 1'b1;
                        end
                        if (state_q == StICyc) begin
                            bus.i_rdata <= bus.wb_ack_i ? bus.wb_dat_i : 32'h0;
                        end else if (!bus.wb_we_o) begin
                            bus.d_rdata <= bus.wb_ack_i ? bus.wb_dat_i : 32'h0;
                        end
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                StDone: begin
                    bus.d_done <= 1'b0;
                    bus.i_done <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arb.sv
// Randomised and directed bench for wb_bus_arb, checked every cycle against a
// transaction-level model of the request/termination/done timeline.
module tb_wb_bus_arb;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_bus_arb_if bus ();

    wb_bus_arb #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a transaction is either on the bus (counting stb cycles), in its
    // done cycle, or absent; it only ever looks at the core and slave inputs.
    bit          m_active = 0, m_done_cyc = 0, m_is_data = 0, m_we = 0;
    bit          m_dd = 0, m_id = 0, m_err = 0;
    logic [31:0] m_adr = 0, m_dat = 0, m_drd = 0, m_ird = 0;
    logic [3:0]  m_sel = 0;
    int          m_stbs = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_done_cyc = 0; m_is_data = 0; m_we = 0;
            m_dd = 0; m_id = 0; m_err = 0;
            m_adr = 0; m_dat = 0; m_drd = 0; m_ird = 0; m_sel = 0; m_stbs = 0;
        end else if (m_done_cyc) begin
            m_done_cyc = 0; m_dd = 0; m_id = 0;
        end else if (m_active) begin
            m_stbs++;
            if (bus.wb_ack_i || bus.wb_err_i || m_stbs == TO + 1) begin
                m_active = 0;
                m_done_cyc = 1;
                if (m_is_data) m_dd = 1; else m_id = 1;
                if (bus.wb_ack_i) begin
                    if (!m_is_data) m_ird = bus.wb_dat_i;
                    else if (!m_we) m_drd = bus.wb_dat_i;
                end else begin
                    m_err = 1;
                    if (!m_is_data) m_ird = 0;
                    else if (!m_we) m_drd = 0;
                end
                m_we = 0;
            end
        end else if (bus.d_req) begin
            m_active = 1; m_is_data = 1; m_stbs = 0;
            m_adr = bus.d_addr; m_we = bus.d_we; m_sel = bus.d_be; m_dat = bus.d_wdata;
        end else if (bus.i_req) begin
            m_active = 1; m_is_data = 0; m_stbs = 0;
            m_adr = bus.i_addr; m_we = 0; m_sel = 4'hF;
        end
    end

    always @(negedge clk) begin
        logic exp_pause;
        exp_pause = (bus.d_req & ~m_dd) | (bus.i_req & ~m_id);
        vectors++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o, bus.wb_dat_o,
             bus.i_rdata, bus.i_done, bus.d_rdata, bus.d_done, bus.pause, bus.bus_err} !==
            {m_active, m_active, m_we, m_adr, m_sel, m_dat,
             m_ird, m_id, m_drd, m_dd, exp_pause, m_err}) begin
            miscompares++;
            $display("FAIL cycle t=%0t cyc/stb/we=%b%b%b/%b%b%b adr=%h/%h sel=%h/%h dat=%h/%h ird=%h/%h idone=%b/%b drd=%h/%h ddone=%b/%b pause=%b/%b err=%b/%b (dut/model)",
                     $time, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, m_active, m_active, m_we,
                     bus.wb_adr_o, m_adr, bus.wb_sel_o, m_sel, bus.wb_dat_o, m_dat,
                     bus.i_rdata, m_ird, bus.i_done, m_id, bus.d_rdata, m_drd,
                     bus.d_done, m_dd, bus.pause, exp_pause, bus.bus_err, m_err);
        end
    end

    // Slave: mode 0 ack, 1 err, 2 never answers, 3 ack and err together.
    bit          sl_rand = 0;
    int          sl_wait = 0, sl_mode = 0, sl_cnt = 0;
    logic [31:0] sl_data = 0;

    always @(posedge clk) begin
        int r;
        #1;
        if (bus.wb_stb_o) begin
            if (sl_cnt == 0 && sl_rand) begin
                sl_wait = int'($urandom_range(0, 3));
                r = int'($urandom_range(0, 9));
                sl_mode = bus.wb_we_o ? 0 : (r < 6 ? 0 : (r == 6 ? 1 : (r == 7 ? 3 : 2)));
            end
            bus.wb_dat_i = sl_rand ? $urandom() : sl_data;
            bus.wb_ack_i = (sl_cnt == sl_wait) && (sl_mode == 0 || sl_mode == 3);
            bus.wb_err_i = (sl_cnt == sl_wait) && (sl_mode == 1 || sl_mode == 3);
            sl_cnt++;
        end else begin
            bus.wb_dat_i = $urandom();
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            sl_cnt = 0;
        end
    end

    // One request from the core side, held until its done pulse, dropped the cycle after.
    task automatic access(input bit is_data, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, output int stbs,
                          output logic [31:0] adr, output logic [3:0] sel, output logic weo,
                          output logic [31:0] dato, output logic pause_done);
        bit seen;
        @(posedge clk); #1;
        if (is_data) begin
            bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_be = be; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1; bus.i_addr = addr;
        end
        stbs = 0; seen = 0; adr = 0; sel = 0; weo = 0; dato = 0; pause_done = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.wb_stb_o) begin
                stbs++; adr = bus.wb_adr_o; sel = bus.wb_sel_o; weo = bus.wb_we_o;
                dato = bus.wb_dat_o;
            end
            if (is_data ? bus.d_done : bus.i_done) begin
                pause_done = bus.pause;
                seen = 1;
                break;
            end
        end
        chk(is_data ? "d_done_seen" : "i_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.d_req = 0; bus.i_req = 0;
    endtask

    initial begin
        int          stbs;
        logic [31:0] adr, dato;
        logic [3:0]  sel;
        logic        weo, pd;

        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_be = 0; bus.d_wdata = 0;

        @(posedge clk); @(posedge clk); #3;
        chk("rst_ctrl", 32'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 32'd0);
        chk("rst_adr_sel_dat", bus.wb_adr_o | bus.wb_dat_o | 32'(bus.wb_sel_o), 32'd0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        chk("rst_flags", 32'({bus.i_done, bus.d_done, bus.bus_err}), 32'd0);
        rst = 0;

        // Data read, ack in the second stb cycle.
        sl_mode = 0; sl_wait = 1; sl_data = 32'h1234_5678;
        access(1, 0, 32'h8000_0010, 4'hF, 32'h0, stbs, adr, sel, weo, dato, pd);
        chk("rd_stb_cycles", 32'(stbs), 32'd2);
        chk("rd_adr", adr, 32'h8000_0010);
        chk("rd_sel", 32'(sel), 32'hF);
        chk("rd_pause_in_done", 32'(pd), 32'd0);
        chk("rd_rdata", bus.d_rdata, 32'h1234_5678);

        // Byte write leaves d_rdata untouched.
        sl_wait = 0; sl_data = 32'hFFFF_FFFF;
        access(1, 1, 32'h0000_0020, 4'b0100, 32'h00AB_0000, stbs, adr, sel, weo, dato, pd);
        chk("wr_we", 32'(weo), 32'd1);
        chk("wr_sel", 32'(sel), 32'b0100);
        chk("wr_dat", dato, 32'h00AB_0000);
        chk("wr_stb_cycles", 32'(stbs), 32'd1);
        chk("wr_rdata_kept", bus.d_rdata, 32'h1234_5678);

        // Simultaneous requests: data first, fetch afterwards, stall held until i_done.
        begin
            int dd_at, id_at, ff_at;
            bit pause_ok, early_fetch, stb_in_done;
            logic fwe;
            logic [3:0] fsel;
            sl_data = 32'hCAFE_F00D;
            @(posedge clk); #1;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.d_be = 4'h3;
            bus.i_req = 1; bus.i_addr = 32'h100;
            dd_at = -1; id_at = -1; ff_at = -1; pause_ok = 1; early_fetch = 0; stb_in_done = 0;
            fwe = 1; fsel = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (dd_at >= 0 && c == dd_at + 1) bus.d_req = 0;
                if (bus.d_done) begin
                    dd_at = c;
                    stb_in_done = bus.wb_stb_o;
                end
                if (bus.wb_stb_o && bus.wb_adr_o == 32'h100) begin
                    if (dd_at < 0) early_fetch = 1;
                    if (ff_at < 0) begin ff_at = c; fwe = bus.wb_we_o; fsel = bus.wb_sel_o; end
                end
                if (bus.i_done) begin id_at = c; break; end
                if (!bus.pause) pause_ok = 0;
            end
            @(posedge clk); #1;
            bus.i_req = 0; bus.d_req = 0;
            chk("both_d_done_seen", 32'(dd_at >= 0), 32'd1);
            chk("both_i_done_seen", 32'(id_at > dd_at), 32'd1);
            chk("both_data_first", 32'(early_fetch), 32'd0);
            chk("both_dead_cycle", 32'(stb_in_done), 32'd0);
            chk("both_fetch_we", 32'(fwe), 32'd0);
            chk("both_fetch_sel", 32'(fsel), 32'hF);
            chk("both_pause_held", 32'(pause_ok), 32'd1);
            chk("both_i_rdata", bus.i_rdata, 32'hCAFE_F00D);
        end

        // Watchdog: TIMEOUT=4 gives five stb cycles, then a sticky error.
        sl_mode = 2;
        access(1, 0, 32'h44, 4'hF, 32'h0, stbs, adr, sel, weo, dato, pd);
        chk("to_stb_cycles", 32'(stbs), 32'd5);
        chk("to_rdata", bus.d_rdata, 32'h0);
        chk("to_bus_err", 32'(bus.bus_err), 32'd1);
        sl_mode = 0; sl_wait = 0; sl_data = 32'h5555_AAAA;
        access(0, 0, 32'h200, 4'h0, 32'h0, stbs, adr, sel, weo, dato, pd);
        chk("sticky_i_rdata", bus.i_rdata, 32'h5555_AAAA);
        chk("sticky_bus_err", 32'(bus.bus_err), 32'd1);

        // Slave error on a fetch.
        sl_mode = 1; sl_wait = 1;
        access(0, 0, 32'h300, 4'h0, 32'h0, stbs, adr, sel, weo, dato, pd);
        chk("ferr_i_rdata", bus.i_rdata, 32'h0);
        chk("ferr_bus_err", 32'(bus.bus_err), 32'd1);

        // Reset while stb is high aborts the cycle without a done pulse.
        begin
            int dones;
            sl_mode = 2;
            @(posedge clk); #1;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.d_be = 4'hF;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (bus.wb_stb_o) break;
            end
            chk("rstm_stb_before", 32'(bus.wb_stb_o), 32'd1);
            #2; rst = 1; #1;
            chk("rstm_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
            chk("rstm_bus_err", 32'(bus.bus_err), 32'd0);
            bus.d_req = 0;
            repeat (2) @(posedge clk);
            #3; rst = 0;
            dones = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                dones += int'(bus.d_done) + int'(bus.i_done);
            end
            chk("rstm_no_done", 32'(dones), 32'd0);
            sl_mode = 0; sl_wait = 2; sl_data = 32'h0BAD_BEEF;
            access(1, 0, 32'h600, 4'hF, 32'h0, stbs, adr, sel, weo, dato, pd);
            chk("rstm_after_stbs", 32'(stbs), 32'd3);
            chk("rstm_after_rdata", bus.d_rdata, 32'h0BAD_BEEF);
        end

        // Random core traffic against a random slave; the per-cycle model does the checking.
        sl_rand = 1;
        begin
            bit d_rel, i_rel;
            d_rel = 0; i_rel = 0;
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk); #1;
                if (bus.d_req) begin
                    if (d_rel) begin
                        d_rel = 0;
                        if ($urandom_range(0, 2) == 0) begin
                            bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom();
                            bus.d_be = 4'($urandom()); bus.d_wdata = $urandom();
                        end else begin
                            bus.d_req = 0;
                        end
                    end else if (bus.d_done) begin
                        d_rel = 1;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom();
                    bus.d_be = 4'($urandom()); bus.d_wdata = $urandom();
                end
                if (bus.i_req) begin
                    if (i_rel) begin
                        i_rel = 0;
                        if ($urandom_range(0, 2) == 0) bus.i_addr = $urandom() & 32'hFFFF_FFFC;
                        else bus.i_req = 0;
                    end else if (bus.i_done) begin
                        i_rel = 1;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.i_req = 1; bus.i_addr = $urandom() & 32'hFFFF_FFFC;
                end
            end
        end
        bus.d_req = 0; bus.i_req = 0;
        repeat (10) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_bus_arb.md
# wb_bus_arb

Two-port WISHBONE master arbiter/sequencer between the mips789 core and the system WISHBONE bus. It accepts instruction-fetch and data requests from the core and runs them one at a time as classic single WISHBONE cycles. It generates the core `pause` stall while a request is outstanding and holds the returned read data stable for the core. A watchdog terminates cycles that no slave acknowledges. It sits between the core pipeline and the address decoder / ack mux.

## Interface
- `TIMEOUT`, 255: cycles with `wb_stb_o` high and no `wb_ack_i`/`wb_err_i` before forced termination; range 1..255.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  instruction fetch request; held high until `i_done`.
- `i_addr`  in  32  fetch address, word aligned.
- `i_rdata`  out  32  fetched word; valid from `i_done` until the next fetch completes.
- `i_done`  out  1  one-cycle pulse: fetch complete.
- `d_req`  in  1  data request; held high until `d_done`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data address.
- `d_be`  in  4  byte enables.
- `d_wdata`  in  32  write data.
- `d_rdata`  out  32  read data; valid from `d_done` until the next data read completes.
- `d_done`  out  1  one-cycle pulse: data access complete.
- `pause`  out  1  core stall, combinational.
- `bus_err`  out  1  sticky; set by `wb_err_i` or by timeout; cleared only by `rst`.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  WISHBONE master controls.
- `wb_adr_o`  out  32  address.
- `wb_sel_o`  out  4  byte selects.
- `wb_dat_o`  out  32  write data.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  slave termination.

## Operation
- FSM states: `IDLE`, `DCYC`, `ICYC`, `DONE`.
- In `IDLE`:
  - `d_req` → `DCYC`. On the transition edge, register `wb_adr_o=d_addr`, `wb_we_o=d_we`, `wb_sel_o=d_be`, `wb_dat_o=d_wdata`, and set `cyc`/`stb`.
  - Otherwise `i_req` → `ICYC`. Register `adr=i_addr`, `we=0`, `sel=4'hF`, `dat_o` unchanged.
  - Data has strict priority when both requests are high together. The fetch is served after the data access finishes.
- In `DCYC`/`ICYC`:
  - On an edge where `wb_ack_i`=1: capture `wb_dat_i` into `d_rdata`/`i_rdata`. Data writes do not update `d_rdata`.
  - On an edge where `wb_err_i`=1, or where the watchdog count reaches `TIMEOUT`: load `32'h0` into the read register and set `bus_err`.
  - In all three cases drop `cyc`/`stb`/`we` on that edge and go to `DONE`.
  - `wb_ack_i` takes precedence over `wb_err_i` when both are high.
- In `DONE`: assert the matching `d_done` or `i_done` for exactly one cycle, then return to `IDLE`.
  - `DONE` provides one dead bus cycle between transactions.
- Watchdog: 8-bit counter, cleared on entry to `DCYC`/`ICYC`, incremented each cycle in those states.
- `pause = (d_req & ~d_done) | (i_req & ~i_done)`.
  - The core advances on the edge ending the `DONE` cycle.
  - A request still high in the cycle after `DONE` is a new request.
- `rst` asserted mid-cycle aborts the access immediately. Bus outputs go low asynchronously. No done pulse is issued.

## Timing
- Reset values:
  - State `IDLE`.
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0.
  - `wb_adr_o`, `wb_dat_o`, `i_rdata`, `d_rdata` = 0.
  - `wb_sel_o` = 0.
  - `i_done`, `d_done`, `bus_err` = 0.
  - `pause` follows the inputs.
- Request latency:
  - Request seen in `IDLE` at edge N → `stb` high after edge N.
  - Ack sampled at edge N+k (k≥1) → `stb` low and `DONE` after N+k.
  - Done pulse during cycle N+k+1.
- Zero-wait slave (ack in the first `stb` cycle): 3 cycles total from request to done, including the `DONE` cycle.
- Timeout: with no ack, `stb` is high for exactly `TIMEOUT`+1 cycles, then `DONE`.
- All outputs except `pause` are registered.

## Test plan
- Data read, ack one cycle after `stb`: `d_addr=32'h8000_0010`, `wb_dat_i=32'h1234_5678` → `stb` high 2 cycles, `adr=32'h8000_0010`, `sel=4'hF` (with `d_be=4'hF`), `d_done` pulse, `d_rdata=32'h1234_5678`, `pause` low in the `DONE` cycle.
- Data write byte: `d_we=1`, `d_be=4'b0100`, `d_wdata=32'h00AB_0000` → `wb_we_o=1`, `wb_sel_o=4'b0100`, `wb_dat_o=32'h00AB_0000`; `d_rdata` unchanged.
- Simultaneous `i_req` and `d_req` → data cycle first, one idle bus cycle (`DONE`), then fetch cycle with `we=0`, `sel=4'hF`; `pause` stays high until `i_done`.
- Timeout with `TIMEOUT=4`, no ack → `stb` high 5 cycles, `d_rdata=0`, `bus_err=1` and sticky through later successful accesses.
- `wb_err_i` on a fetch → `i_rdata=0`, `bus_err=1`, `i_done` pulse.
- `rst` pulse while `stb` is high → `cyc`/`stb` low immediately, no done pulse, `bus_err=0`; a new `d_req` after reset runs normally.
